// File: rtl/out_pixel_packer_wide_pkg.sv
// Shared types and constants for the wide pixel
// read/write paths.
package out_pixel_packer_wide_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W = BYTES_PER_WORD * 8;

  typedef enum logic {
    ST_EMPTY,
    ST_PARTIAL
  } state_e;

  // Expand a lane mask into a per-bit data mask.
  function automatic logic [WORD_W-1:0] lane_mask(
    input logic [BYTES_PER_WORD-1:0] m
  );
    logic [WORD_W-1:0] r;
    r = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++)
      r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

endpackage

// File: rtl/out_pixel_packer_wide.sv
// Packs byte pixel writes into 32-bit masked word
// writes, with flush handshake and perf counters.
module out_pixel_packer_wide
  import out_pixel_packer_wide_pkg::*;
#(
  parameter int AW    = 10,
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AW+1:0]             in_waddr,
  input  logic [7:0]                in_wdata,
  input  logic                      in_we,
  input  logic                      i_flush,
  output logic                      o_flush_done,
  output logic [AW-1:0]             mem_waddr,
  output logic [WORD_W-1:0]         mem_wdata,
  output logic [BYTES_PER_WORD-1:0] mem_wbe,
  output logic                      mem_we,
  output logic                      o_pending,
  output logic [CNT_W-1:0]          o_byte_count,
  output logic [CNT_W-1:0]          o_word_count
);

  state_e                    state;
  logic [AW-1:0]             buf_addr;
  logic [WORD_W-1:0]         buf_data;
  logic [BYTES_PER_WORD-1:0] buf_mask;
  logic                      flush_pending;

  logic [1:0]                lane;
  logic [AW-1:0]             word;
  logic                      partial;
  logic                      diff;
  logic                      flush_trig;
  logic [AW-1:0]             nb_addr;
  logic [WORD_W-1:0]         nb_data;
  logic [BYTES_PER_WORD-1:0] nb_mask;
  logic                      nb_valid;
  logic                      issue_new;
  logic                      wr;
  logic [AW-1:0]             wr_addr;
  logic [WORD_W-1:0]         wr_data;
  logic [BYTES_PER_WORD-1:0] wr_mask;
  logic                      done;

  function automatic logic [WORD_W-1:0] merge_lane(
    input logic [WORD_W-1:0] d,
    input logic [1:0]        ln,
    input logic [7:0]        b
  );
    logic [WORD_W-1:0] r;
    r = d;
    r[{ln, 3'b000} +: 8] = b;
    return r;
  endfunction

  assign lane       = in_waddr[1:0];
  assign word       = in_waddr[AW+1:2];
  assign partial    = (state == ST_PARTIAL);
  assign o_pending  = partial;
  // a pending flush keeps acting as a flush, so a
  // re-asserted i_flush adds nothing
  assign flush_trig = i_flush | flush_pending;
  assign diff       = in_we & partial &
                      (word != buf_addr);

  // Merge the incoming byte and decide what to write.
  always_comb begin
    nb_addr = buf_addr;
    nb_data = buf_data;
    nb_mask = buf_mask;
    if (in_we) begin
      if (!partial || diff) begin
        nb_addr = word;
        nb_data = merge_lane('0, lane, in_wdata);
        nb_mask = BYTES_PER_WORD'(1) << lane;
      end else begin
        nb_data = merge_lane(buf_data, lane, in_wdata);
        nb_mask = buf_mask |
                  (BYTES_PER_WORD'(1) << lane);
      end
    end
    nb_valid  = partial | in_we;
    done      = flush_trig & ~diff;
    issue_new = nb_valid & ((&nb_mask) | done);
    wr        = diff | issue_new;
    wr_addr   = diff ? buf_addr : nb_addr;
    wr_mask   = diff ? buf_mask : nb_mask;
    wr_data   = (diff ? buf_data : nb_data) &
                lane_mask(wr_mask);
  end

  // Buffer FSM, registered write port and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_EMPTY;
      buf_addr      <= '0;
      buf_data      <= '0;
      buf_mask      <= '0;
      flush_pending <= 1'b0;
      mem_we        <= 1'b0;
      mem_wbe       <= '0;
      mem_waddr     <= '0;
      mem_wdata     <= '0;
      o_flush_done  <= 1'b0;
      o_byte_count  <= '0;
      o_word_count  <= '0;
    end else begin
      flush_pending <= flush_trig & diff;
      o_flush_done  <= done;
      mem_we        <= wr;
      mem_wbe       <= wr ? wr_mask : '0;
      if (wr) begin
        mem_waddr <= wr_addr;
        mem_wdata <= wr_data;
      end
      o_byte_count <= o_byte_count +
                      CNT_W'(in_we);
      o_word_count <= o_word_count +
                      CNT_W'(wr);
      if (issue_new || !nb_valid) begin
        state    <= ST_EMPTY;
        buf_mask <= '0;
        buf_data <= '0;
      end else begin
        state    <= ST_PARTIAL;
        buf_addr <= nb_addr;
        buf_data <= nb_data;
        buf_mask <= nb_mask;
      end
    end
  end

endmodule

// File: doc/out_pixel_packer_wide.md
OUT_PIXEL_PACKER_WIDE -- requirements
Module: out_pixel_packer_wide

Interface
REQ-001 SHALL have parameter AW, default 10, meaning the word-address width of the 32-bit wide output memory.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the performance counters.
REQ-003 SHALL have port clk  input  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_waddr  input  AW+2  byte address of the pixel write; [1:0] is the lane, [AW+1:2] is the word.
REQ-006 SHALL have port in_wdata  input  8  pixel byte.
REQ-007 SHALL have port in_we  input  1  pixel write strobe, one byte per cycle, never back-pressured.
REQ-008 SHALL have port i_flush  input  1  request to write out any partial word.
REQ-009 SHALL have port o_flush_done  output  1  one-cycle pulse when the flush completes.
REQ-010 SHALL have port mem_waddr  output  AW  wide-memory word address.
REQ-011 SHALL have port mem_wdata  output  32  packed word; lane n occupies bits [8n+7:8n].
REQ-012 SHALL have port mem_wbe  output  4  byte enables, bit n = lane n.
REQ-013 SHALL have port mem_we  output  1  wide write strobe; the memory accepts it in the same cycle.
REQ-014 SHALL have port o_pending  output  1  high while the buffer holds unwritten bytes.
REQ-015 SHALL have ports o_byte_count and o_word_count  output  CNT_W each  counts of accepted bytes and of issued wide writes.

Function
REQ-016 SHALL use two states:
- ST_EMPTY: buffer invalid.
- ST_PARTIAL: buffer holds a word address, a 32-bit data register and a 4-bit valid mask.
REQ-017 SHALL register every mem_* output, so each wide write appears exactly one cycle after the triggering input cycle.
REQ-018 SHALL, on in_we in ST_EMPTY, load the word address, set lane data and its mask bit, and go to ST_PARTIAL.
REQ-019 SHALL, on in_we in ST_PARTIAL to the same word, merge the byte; a repeated lane is overwritten and keeps a single mask bit.
REQ-020 SHALL, when the mask becomes 4'b1111, issue the write (mem_wbe=4'hF) next cycle and return to ST_EMPTY.
REQ-021 SHALL, on in_we in ST_PARTIAL to a different word, issue the old buffer with its mask next cycle and simultaneously start a new buffer holding only the new byte, with no stall.
REQ-022 SHALL, on i_flush in ST_EMPTY with no in_we, pulse o_flush_done the next cycle and issue no write.
REQ-023 SHALL, on i_flush in ST_PARTIAL, merge any same-cycle same-word byte first, then issue the buffer next cycle with o_flush_done asserted in the same cycle as mem_we.
REQ-024 SHALL, on i_flush coinciding with a different-word in_we, issue the old word next cycle and hold a flush_pending flag.
- The new word is issued the cycle after that, together with o_flush_done.
REQ-025 SHALL ignore i_flush re-asserted while flush_pending is set; o_flush_done pulses once.
REQ-026 SHALL, when the input stays idle, hold the buffer indefinitely; there is no timeout write.
REQ-027 SHALL increment o_byte_count per accepted in_we and o_word_count per mem_we; both wrap modulo 2^CNT_W.
REQ-028 SHALL drive mem_wdata lanes with mask bit 0 to 8'h00.
REQ-029 SHALL assert o_pending exactly when the state is ST_PARTIAL.

Reset
REQ-030 SHALL, on rst high at a clock edge, set the state to ST_EMPTY, clear the mask and flush_pending, and drive mem_we=0, mem_wbe=0, mem_waddr=0, mem_wdata=0, o_flush_done=0, o_pending=0, and both counters to 0.
REQ-031 SHALL, on reset mid-word, discard the partial buffer with no write; rst dominates in_we and i_flush in the same cycle.

Structure
REQ-032 SHALL place the state enum and the constant BYTES_PER_WORD=4 in the shared bilinear package, used by the wide read and write paths.
REQ-033 SHALL be a single module with no sub-module; lane merging is a local function.

Verification
REQ-034 SHALL verify a full word: bytes 0x11,0x22,0x33,0x44 to addresses 0x40..0x43 on consecutive cycles -> one cycle after the last byte, mem_we=1, mem_waddr=0x10, mem_wdata=0x44332211, mem_wbe=4'hF.
REQ-035 SHALL verify a word change: bytes 0xAA@0x41, then 0xBB@0x48 -> write waddr=0x10, wbe=4'b0010, wdata=0x0000AA00; o_pending stays 1 for word 0x12.
REQ-036 SHALL verify a flush race: byte 0xCC@0x05 buffered, then 0xDD@0x0C with i_flush -> write waddr=0x01, wbe=4'b0010, then next cycle write waddr=0x03, wbe=4'b0001 with o_flush_done=1.
REQ-037 SHALL verify a lane overwrite: 0x10@0x20 then 0x99@0x20, then i_flush -> single write wdata=0x00000099, wbe=4'b0001; o_byte_count=2, o_word_count=1.
REQ-038 SHALL verify reset mid-word: two bytes buffered, then rst -> no mem_we ever, o_pending=0, counters 0; a subsequent i_flush gives o_flush_done only.
